code_match_table: RTL and testbench



---
 rtl/code_match_table.sv | 128 ++++++++++++
 tb/tb_code_match_table.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_match_table.sv
// Programmable pattern/mask lookup table with registered code, hit flag,
// hit index and saturating hit/miss counters.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cfg_we/cfg_idx    table write strobe and target entry
//   cfg_valid         entry enable
//   cfg_pattern       compare pattern
//   cfg_mask          compare mask (1 = compare, 0 = don't care)
//   cfg_code          code returned on a match
//   in_valid/data_in  lookup request
//   cnt_clr           synchronous clear of both counters
//   out_valid         qualifies data_out/hit/hit_idx
//   data_out          matched code or DEFAULT_CODE on a miss
//   hit/hit_idx       match flag and winning entry (0 on a miss)
//   hit_cnt/miss_cnt  saturating lookup statistics
module code_match_table #(
  parameter int DATA_W = 6,
  parameter int OUT_W = 3,
  parameter int ENTRIES = 8,
  parameter int IDX_W = $clog2(ENTRIES),
  parameter logic [OUT_W-1:0] DEFAULT_CODE = '0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic              cfg_valid,
  input  logic [DATA_W-1:0] cfg_pattern,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [OUT_W-1:0]  cfg_code,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [OUT_W-1:0]  data_out,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  logic [ENTRIES-1:0] tbl_valid;
  logic [DATA_W-1:0]  tbl_pattern [ENTRIES];
  logic [DATA_W-1:0]  tbl_mask    [ENTRIES];
  logic [OUT_W-1:0]   tbl_code    [ENTRIES];

  logic               match_any;
  logic [IDX_W-1:0]   match_idx;
  logic [OUT_W-1:0]   match_code;

  // Scan from the top down so the lowest matching index is the
  // last assignment and therefore wins.
  always_comb begin
    match_any  = 1'b0;
    match_idx  = '0;
    match_code = DEFAULT_CODE;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl_valid[i] &&
          (((data_in ^ tbl_pattern[i]) & tbl_mask[i]) == '0)) begin
        match_any  = 1'b1;
        match_idx  = IDX_W'(i);
        match_code = tbl_code[i];
      end
    end
  end

  // Only indices that exist are decoded, so an out-of-range
  // cfg_idx leaves the table untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_pattern[i] <= '0;
        tbl_mask[i]    <= '0;
        tbl_code[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (cfg_we && (cfg_idx == IDX_W'(i))) begin
          tbl_valid[i]   <= cfg_valid;
          tbl_pattern[i] <= cfg_pattern;
          tbl_mask[i]    <= cfg_mask;
          tbl_code[i]    <= cfg_code;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= DEFAULT_CODE;
      hit       <= 1'b0;
      hit_idx   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= match_code;
        hit      <= match_any;
        hit_idx  <= match_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      unique case (1'b1)
        cnt_clr: begin
          hit_cnt  <= '0;
          miss_cnt <= '0;
        end
        (!cnt_clr && in_valid && match_any): begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end
        (!cnt_clr && in_valid && !match_any): begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_code_match_table.sv
// Randomized and directed bench for code_match_table against a
// first-match behavioural table model.
module tb_code_match_table;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [2:0] cfg_idx;
  logic       cfg_valid;
  logic [5:0] cfg_pattern;
  logic [5:0] cfg_mask;
  logic [2:0] cfg_code;
  logic       in_valid;
  logic [5:0] data_in;
  logic       cnt_clr;
  logic       out_valid;
  logic [2:0] data_out;
  logic       hit;
  logic [2:0] hit_idx;
  logic [7:0] hit_cnt;
  logic [7:0] miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit         m_v [8];
  logic [5:0] m_p [8];
  logic [5:0] m_m [8];
  logic [2:0] m_c [8];
  logic       e_ov;
  logic [2:0] e_do;
  logic       e_hit;
  logic [2:0] e_idx;
  int         e_hc;
  int         e_mc;

  code_match_table dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_valid(cfg_valid),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_code(cfg_code), .in_valid(in_valid), .data_in(data_in),
    .cnt_clr(cnt_clr), .out_valid(out_valid), .data_out(data_out),
    .hit(hit), .hit_idx(hit_idx), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_v[i] = 0; m_p[i] = '0; m_m[i] = '0; m_c[i] = '0;
    end
    e_ov = 0; e_do = 0; e_hit = 0; e_idx = 0; e_hc = 0; e_mc = 0;
  endtask

  // first entry whose masked bits equal the word, -1 if none
  function automatic int find(input logic [5:0] d);
    for (int i = 0; i < 8; i++)
      if (m_v[i] && ((d & m_m[i]) == (m_p[i] & m_m[i])))
        return i;
    return -1;
  endfunction

  task automatic idle();
    cfg_we = 0; cfg_idx = 0; cfg_valid = 0; cfg_pattern = 0;
    cfg_mask = 0; cfg_code = 0; in_valid = 0; data_in = 0;
    cnt_clr = 0;
  endtask

  // one clock: model sees the inputs as the DUT does at the edge,
  // then returns at the falling edge where outputs are stable
  task automatic step();
    int k;
    @(posedge clk);
    k = -1;
    if (in_valid) begin
      k = find(data_in);
      e_ov = 1;
      e_hit = (k >= 0);
      e_idx = (k >= 0) ? 3'(k) : 3'd0;
      e_do = (k >= 0) ? m_c[k] : 3'd0;
    end else begin
      e_ov = 0;
    end
    if (cnt_clr) begin
      e_hc = 0; e_mc = 0;
    end else if (in_valid) begin
      if (k >= 0) e_hc = (e_hc < 255) ? e_hc + 1 : 255;
      else        e_mc = (e_mc < 255) ? e_mc + 1 : 255;
    end
    if (cfg_we && cfg_idx < 8) begin
      m_v[cfg_idx] = cfg_valid;
      m_p[cfg_idx] = cfg_pattern;
      m_m[cfg_idx] = cfg_mask;
      m_c[cfg_idx] = cfg_code;
    end
    @(negedge clk);
  endtask

  task automatic wr(input int idx, input bit v, input logic [5:0] p,
                    input logic [5:0] m, input logic [2:0] c);
    cfg_we = 1; cfg_idx = 3'(idx); cfg_valid = v;
    cfg_pattern = p; cfg_mask = m; cfg_code = c;
    step();
    cfg_we = 0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, data_out, hit, hit_idx, hit_cnt, miss_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ov=%0b do=%0d hit=%0b idx=%0d hc=%0d mc=%0d want all 0",
               out_valid, data_out, hit, hit_idx, hit_cnt, miss_cnt);
    end
    in_valid = 1; data_in = 6'b101010;
    step();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1 || hit !== 0 || data_out !== 3'd0 || miss_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL first_miss: got ov=%0b hit=%0b do=%0d mc=%0d want 1 0 0 1",
               out_valid, hit, data_out, miss_cnt);
    end
  endtask

  task automatic test_program_stream();
    logic [5:0] w [5];
    logic [2:0] c [5];
    w = '{6'b101010, 6'b101100, 6'b101101, 6'b011011, 6'b101111};
    c = '{3'b111, 3'b010, 3'b110, 3'b011, 3'b001};
    for (int i = 0; i < 5; i++) wr(i, 1, w[i], 6'b111111, c[i]);
    n_cmp++;
    if (out_valid !== 0) begin
      n_bad++;
      $display("FAIL idle_out_valid: got %0b want 0", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; data_in = w[i];
      step();
      n_cmp++;
      if (out_valid !== 1 || hit !== 1 || data_out !== c[i] || hit_idx !== 3'(i)) begin
        n_bad++;
        $display("FAIL stream_%0d: got ov=%0b hit=%0b do=%b idx=%0d want 1 1 %b %0d",
                 i, out_valid, hit, data_out, hit_idx, c[i], i);
      end
    end
    in_valid = 0;
    n_cmp++;
    if (hit_cnt !== 8'd5 || hit_cnt !== 8'(e_hc)) begin
      n_bad++;
      $display("FAIL stream_hit_cnt: got %0d want 5", hit_cnt);
    end
  endtask

  task automatic test_priority_mask();
    wr(2, 0, 6'b0, 6'b0, 3'b0);
    wr(1, 1, 6'b101100, 6'b111110, 3'b101);
    wr(3, 1, 6'b101101, 6'b111111, 3'b110);
    in_valid = 1; data_in = 6'b101101;
    step();
    in_valid = 0;
    n_cmp++;
    if (data_out !== 3'b101 || hit_idx !== 3'd1 || hit !== 1) begin
      n_bad++;
      $display("FAIL prio_low_idx: got do=%b idx=%0d want 101 1", data_out, hit_idx);
    end
    wr(1, 0, 6'b101100, 6'b111110, 3'b101);
    in_valid = 1; data_in = 6'b101101;
    step();
    in_valid = 0;
    n_cmp++;
    if (data_out !== 3'b110 || hit_idx !== 3'd3 || hit !== 1) begin
      n_bad++;
      $display("FAIL prio_after_clear: got do=%b idx=%0d want 110 3", data_out, hit_idx);
    end
  endtask

  task automatic test_same_cycle();
    cfg_we = 1; cfg_idx = 0; cfg_valid = 1;
    cfg_pattern = 6'b000111; cfg_mask = 6'b111111; cfg_code = 3'b100;
    in_valid = 1; data_in = 6'b000111;
    step();
    cfg_we = 0;
    n_cmp++;
    if (out_valid !== 1 || hit !== 0 || data_out !== 3'd0 || hit_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL same_cycle_old: got hit=%0b do=%b idx=%0d want 0 000 0",
               hit, data_out, hit_idx);
    end
    step();
    in_valid = 0;
    n_cmp++;
    if (hit !== 1 || data_out !== 3'b100 || hit_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL same_cycle_new: got hit=%0b do=%b want 1 100", hit, data_out);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 300; n++) begin
      idle();
      r = $urandom_range(0, 9);
      if (r < 2) begin
        cfg_we = 1; cfg_idx = 3'($urandom);
        cfg_valid = ($urandom_range(0, 3) != 0);
        cfg_pattern = 6'($urandom);
        cfg_mask = ($urandom_range(0, 1) == 1) ? 6'b111111 : 6'($urandom);
        cfg_code = 3'($urandom);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      data_in = ($urandom_range(0, 2) != 0) ? (m_p[r] ^ 6'(($urandom_range(0, 3) == 0) << $urandom_range(0, 5)))
                                            : 6'($urandom);
      cnt_clr = ($urandom_range(0, 40) == 0);
      step();
      n_cmp++;
      if (out_valid !== e_ov || data_out !== e_do || hit !== e_hit ||
          hit_idx !== e_idx || hit_cnt !== 8'(e_hc) || miss_cnt !== 8'(e_mc)) begin
        n_bad++;
        $display("FAIL random_%0d: got ov=%0b do=%0d hit=%0b idx=%0d hc=%0d mc=%0d want %0b %0d %0b %0d %0d %0d",
                 n, out_valid, data_out, hit, hit_idx, hit_cnt, miss_cnt,
                 e_ov, e_do, e_hit, e_idx, e_hc, e_mc);
      end
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) wr(i, 0, 6'b0, 6'b0, 3'b0);
    cnt_clr = 1;
    step();
    cnt_clr = 0;
    for (int n = 0; n < 300; n++) begin
      in_valid = 1; data_in = 6'($urandom);
      step();
    end
    in_valid = 0;
    n_cmp++;
    if (miss_cnt !== 8'd255 || e_mc != 255) begin
      n_bad++;
      $display("FAIL miss_saturate: got %0d want 255", miss_cnt);
    end
    step();
    n_cmp++;
    if (miss_cnt !== 8'd255 || out_valid !== 0) begin
      n_bad++;
      $display("FAIL miss_hold: got mc=%0d ov=%0b want 255 0", miss_cnt, out_valid);
    end
  endtask

  task automatic test_clear();
    wr(5, 1, 6'b110011, 6'b111111, 3'b011);
    in_valid = 1; data_in = 6'b110011;
    step();
    n_cmp++;
    if (hit_cnt !== 8'd1 || hit_idx !== 3'd5) begin
      n_bad++;
      $display("FAIL pre_clear_hit: got hc=%0d idx=%0d want 1 5", hit_cnt, hit_idx);
    end
    cnt_clr = 1;
    step();
    cnt_clr = 0; in_valid = 0;
    n_cmp++;
    if (hit_cnt !== 8'd0 || miss_cnt !== 8'd0 || out_valid !== 1 || hit !== 1) begin
      n_bad++;
      $display("FAIL clear_wins: got hc=%0d mc=%0d ov=%0b hit=%0b want 0 0 1 1",
               hit_cnt, miss_cnt, out_valid, hit);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1; data_in = 6'b110011;
    step();
    step();
    n_cmp++;
    if (hit_cnt !== 8'd2 || hit !== 1 || data_out !== 3'b011) begin
      n_bad++;
      $display("FAIL pre_reset_hits: got hc=%0d hit=%0b do=%b want 2 1 011",
               hit_cnt, hit, data_out);
    end
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({out_valid, data_out, hit, hit_idx, hit_cnt, miss_cnt} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got ov=%0b do=%0d hit=%0b idx=%0d hc=%0d mc=%0d want all 0",
               out_valid, data_out, hit, hit_idx, hit_cnt, miss_cnt);
    end
    model_reset();
    @(negedge clk);
    idle();
    rst_n = 1;
    in_valid = 1; data_in = 6'b110011;
    step();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1 || hit !== 0 || data_out !== 3'd0 || miss_cnt !== 8'd1 ||
        hit_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL post_reset_miss: got ov=%0b hit=%0b do=%0d hc=%0d mc=%0d want 1 0 0 0 1",
               out_valid, hit, data_out, hit_cnt, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_program_stream();
    test_priority_mask();
    test_same_cycle();
    test_random();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
